// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared state encoding and default widths for the register dump path
package reg_dump_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;
    localparam int REG_COUNT  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_READ = READ,
        ST_SEND = SEND,
        ST_FIN  = FIN
    } dump_state_t;

    // Bits needed to hold max_value; never less than one so counters stay legal.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/reg_file_dumper_if.sv
// rtl/reg_file_dumper_if.sv - {address, data} beat stream leaving the register dumper
interface reg_file_dumper_if #(
    parameter int ADDR_W = reg_dump_pkg::REG_ADDR_W,
    parameter int DATA_W = reg_dump_pkg::REG_DATA_W
);
    logic [DATA_W-1:0] OUTDATA;
    logic [ADDR_W-1:0] OUTADDR;
    logic              OUTVALID;
    logic              OUTREADY;

    modport master (
        output OUTDATA,
        output OUTADDR,
        output OUTVALID,
        input  OUTREADY
    );

    modport slave (
        input  OUTDATA,
        input  OUTADDR,
        input  OUTVALID,
        output OUTREADY
    );
endinterface

// File: rtl/reg_file_dumper_settle_counter.sv
// rtl/reg_file_dumper_settle_counter.sv - loadable down-counter timing the register file read settle
module reg_file_dumper_settle_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/reg_file_dumper.sv
// rtl/reg_file_dumper.sv - walks the register file read port and streams every register as an {addr, data} beat
module reg_file_dumper
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS      = REG_COUNT,
    parameter int ADDR_W        = REG_ADDR_W,
    parameter int DATA_W        = REG_DATA_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    output logic [ADDR_W-1:0]     RDADDRESS,
    input  logic [DATA_W-1:0]     RDDATA,
    reg_file_dumper_if.master     stream,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int                CNT_W       = cnt_width(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       state_next;
    logic              settle_load;
    logic              settle_done;
    logic              capture;
    logic              handshake;
    logic              last_beat;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    assign handshake = (state == ST_SEND) && stream.OUTREADY;
    assign last_beat = (RDADDRESS == LAST_ADDR);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        settle_load = 1'b0;
        capture     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_next  = ST_READ;
                    settle_load = 1'b1;
                end
            end
            ST_READ: begin
                if (settle_done) begin
                    state_next = ST_SEND;
                    capture    = 1'b1;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    state_next  = last_beat ? ST_FIN : ST_READ;
                    settle_load = !last_beat;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    reg_file_dumper_settle_counter #(
        .WIDTH(CNT_W)
    ) u_settle (
        .clk       (CLK),
        .resetn    (RESET),
        .load      (settle_load),
        .load_value(SETTLE_LOAD),
        .en        (state == ST_READ),
        .done      (settle_done)
    );

    // Termination is by compare with the last address, so partial maps never drive higher addresses.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            RDADDRESS <= '0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            if ((state == ST_IDLE) && START) begin
                RDADDRESS <= '0;
            end else if (handshake) begin
                RDADDRESS <= last_beat ? '0 : RDADDRESS + 1'b1;
            end
            if (capture) begin
                out_data <= RDDATA;
                out_addr <= RDADDRESS;
            end
        end
    end

    assign stream.OUTDATA  = out_data;
    assign stream.OUTADDR  = out_addr;
    assign stream.OUTVALID = (state == ST_SEND);
    assign BUSY            = (state != ST_IDLE);
    assign DONE            = (state == ST_FIN);

endmodule

// File: tb/tb_reg_file_dumper.sv
// tb/tb_reg_file_dumper.sv - scoreboard bench for reg_file_dumper in default and slow/partial configurations
module tb_reg_file_dumper;
    import reg_dump_pkg::*;

    localparam int B_REGS   = 5;
    localparam int B_SETTLE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [2:0] rdaddr_a, rdaddr_b;
    logic [7:0] rddata_a, rddata_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] regs_a [8];
    logic [7:0] regs_b [8];
    logic [2:0] b_addr_d1 = '0;
    logic [2:0] b_addr_d2 = '0;

    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];

    reg_file_dumper_if #(.ADDR_W(3), .DATA_W(8)) sa ();
    reg_file_dumper_if #(.ADDR_W(3), .DATA_W(8)) sb ();

    reg_file_dumper dut_a (
        .CLK(clk), .RESET(rst_n), .START(start_a), .RDADDRESS(rdaddr_a), .RDDATA(rddata_a),
        .stream(sa), .BUSY(busy_a), .DONE(done_a)
    );

    reg_file_dumper #(
        .NUM_REGS(B_REGS), .ADDR_W(3), .DATA_W(8), .SETTLE_CYCLES(B_SETTLE)
    ) dut_b (
        .CLK(clk), .RESET(rst_n), .START(start_b), .RDADDRESS(rdaddr_b), .RDDATA(rddata_b),
        .stream(sb), .BUSY(busy_b), .DONE(done_b)
    );

    // Register file A answers at once; B shows new data only two cycles after its address moves.
    assign rddata_a = regs_a[rdaddr_a];
    always @(posedge clk) begin
        b_addr_d1 <= rdaddr_b;
        b_addr_d2 <= b_addr_d1;
    end
    assign rddata_b = regs_b[b_addr_d2];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    int beats_a = 0, dones_a = 0, rise_a = 0, lat_a = 0, done_cyc_a = 0;
    logic pv_a = 1'b0, pr_a = 1'b0, prst_a = 1'b0;
    logic [2:0] pad_a = '0;
    logic [7:0] pdat_a = '0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && prst_a && pv_a && !pr_a) begin
            check("a_hold_valid", sa.OUTVALID, 1);
            check("a_hold_addr", sa.OUTADDR, pad_a);
            check("a_hold_data", sa.OUTDATA, pdat_a);
        end
        if (rst_n && sa.OUTVALID && !pv_a) rise_a = cyc;
        if (rst_n && sa.OUTVALID && sa.OUTREADY) begin
            beats_a++;
            if (sa.OUTADDR == 3'd0) lat_a = rise_a;
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_beat: got addr %0d want no beat", sa.OUTADDR);
            end else begin
                e = exp_a.pop_front();
                check("a_beat_addr", sa.OUTADDR, e[10:8]);
                check("a_beat_data", sa.OUTDATA, e[7:0]);
            end
        end
        if (rst_n && done_a) begin
            dones_a++;
            done_cyc_a = cyc;
        end
        pv_a = sa.OUTVALID; pr_a = sa.OUTREADY; prst_a = rst_n;
        pad_a = sa.OUTADDR; pdat_a = sa.OUTDATA;
    end

    int beats_b = 0, dones_b = 0, rise_b = 0, lat_b = 0, done_cyc_b = 0, max_b = 0;
    logic pv_b = 1'b0, pr_b = 1'b0, prst_b = 1'b0;
    logic [2:0] pad_b = '0;
    logic [7:0] pdat_b = '0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && int'(rdaddr_b) > max_b) max_b = rdaddr_b;
        if (rst_n && prst_b && pv_b && !pr_b) begin
            check("b_hold_valid", sb.OUTVALID, 1);
            check("b_hold_addr", sb.OUTADDR, pad_b);
            check("b_hold_data", sb.OUTDATA, pdat_b);
        end
        if (rst_n && sb.OUTVALID && !pv_b) rise_b = cyc;
        if (rst_n && sb.OUTVALID && sb.OUTREADY) begin
            beats_b++;
            if (sb.OUTADDR == 3'd0) lat_b = rise_b;
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_beat: got addr %0d want no beat", sb.OUTADDR);
            end else begin
                e = exp_b.pop_front();
                check("b_beat_addr", sb.OUTADDR, e[10:8]);
                check("b_beat_data", sb.OUTDATA, e[7:0]);
            end
        end
        if (rst_n && done_b) begin
            dones_b++;
            done_cyc_b = cyc;
        end
        pv_b = sb.OUTVALID; pr_b = sb.OUTREADY; prst_b = rst_n;
        pad_b = sb.OUTADDR; pdat_b = sb.OUTDATA;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 while the dumper is idle; returns the START sampling edge number.
    task automatic start_a_dump(output int s);
        start_a = 1'b1;
        tick();
        s = cyc;
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) exp_a.push_back({5'd0, 3'(i), regs_a[i]});
    endtask

    task automatic start_b_dump(output int s);
        start_b = 1'b1;
        tick();
        s = cyc;
        start_b = 1'b0;
        for (int i = 0; i < B_REGS; i++) exp_b.push_back({5'd0, 3'(i), regs_b[i]});
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = dones_a;
        for (int k = 0; k < budget && dones_a == n; k++) begin
            @(negedge clk);
            #1;
        end
        if (dones_a == n) begin
            checks++;
            errors++;
            $display("FAIL a_done_timeout: got no DONE within %0d cycles want DONE", budget);
        end
    endtask

    task automatic wait_done_b(input int budget);
        int n;
        n = dones_b;
        for (int k = 0; k < budget && dones_b == n; k++) begin
            @(negedge clk);
            #1;
        end
        if (dones_b == n) begin
            checks++;
            errors++;
            $display("FAIL b_done_timeout: got no DONE within %0d cycles want DONE", budget);
        end
    endtask

    initial begin
        int s, n, k, b0;
        sa.OUTREADY = 1'b1;
        sb.OUTREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            regs_a[i] = 8'h10 + 8'(i);
            regs_b[i] = {3'(i), 5'($urandom)};
        end

        repeat (3) tick();
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_valid_a", sa.OUTVALID, 0);
        check("rst_rdaddr_a", rdaddr_a, 0);
        check("rst_outaddr_a", sa.OUTADDR, 0);
        check("rst_outdata_a", sa.OUTDATA, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_valid_b", sb.OUTVALID, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy_a", busy_a, 0);

        // Basic dump, sink always ready.
        b0 = beats_a;
        start_a_dump(s);
        wait_done_a(100);
        check("a_done_cycle", done_cyc_a - s, 16);
        check("a_first_latency", lat_a - s, 1);
        check("a_fin_rdaddr", rdaddr_a, 0);
        check("a_beats", beats_a - b0, 8);
        tick();
        check("a_busy_after", busy_a, 0);
        check("a_done_pulse", done_a, 0);
        check("a_queue_empty", exp_a.size(), 0);

        // Backpressure on beat 3.
        tick();
        n = dones_a;
        start_a_dump(s);
        k = 0;
        while (!(rdaddr_a == 3'd3 && !sa.OUTVALID) && k < 100) begin
            tick();
            k++;
        end
        check("a_reach_addr3", rdaddr_a, 3);
        sa.OUTREADY = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("a_stall_valid", sa.OUTVALID, 1);
            check("a_stall_addr", sa.OUTADDR, 3);
            check("a_stall_data", sa.OUTDATA, 8'h13);
            check("a_stall_rdaddr", rdaddr_a, 3);
        end
        tick();
        sa.OUTREADY = 1'b1;
        wait_done_a(100);
        check("a_bp_dones", dones_a - n, 1);
        tick();
        check("a_bp_queue", exp_a.size(), 0);

        // Randomized register contents and sink readiness.
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 8; i++) regs_a[i] = 8'($urandom);
            n = dones_a;
            start_a_dump(s);
            for (int c = 0; c < 400 && dones_a == n; c++) begin
                sa.OUTREADY = 1'($urandom_range(0, 1));
                tick();
            end
            sa.OUTREADY = 1'b1;
            check("a_rand_dones", dones_a - n, 1);
            check("a_rand_queue", exp_a.size(), 0);
            tick();
        end

        // START while busy and during FIN is ignored; START right after IDLE re-entry is honoured.
        for (int i = 0; i < 8; i++) regs_a[i] = 8'($urandom);
        n = dones_a;
        start_a_dump(s);
        k = 0;
        while (!(sa.OUTVALID && sa.OUTADDR == 3'd4) && k < 100) begin
            tick();
            k++;
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a(100);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_fin_start_ignored", busy_a, 0);
        start_a_dump(s);
        wait_done_a(100);
        check("a_restart_latency", lat_a - s, 1);
        check("a_busy_start_dones", dones_a - n, 2);
        tick();
        check("a_busy_start_queue", exp_a.size(), 0);

        // Reset while beat 5 is on the stream.
        n = dones_a;
        start_a_dump(s);
        k = 0;
        while (!(sa.OUTVALID && sa.OUTADDR == 3'd5) && k < 100) begin
            tick();
            k++;
        end
        rst_n = 1'b0;
        exp_a.delete();
        tick();
        check("a_rst_valid", sa.OUTVALID, 0);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_rdaddr", rdaddr_a, 0);
        check("a_rst_done", done_a, 0);
        check("a_rst_outaddr", sa.OUTADDR, 0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("a_rst_no_done", dones_a - n, 0);
        b0 = beats_a;
        start_a_dump(s);
        wait_done_a(100);
        check("a_post_rst_beats", beats_a - b0, 8);
        tick();
        check("a_post_rst_queue", exp_a.size(), 0);

        // Slow settle with a lagging register file and a five-register map.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) regs_b[i] = {3'(i), 5'($urandom)};
            b0 = beats_b;
            start_b_dump(s);
            if (d == 0) begin
                wait_done_b(200);
            end else begin
                n = dones_b;
                for (int c = 0; c < 400 && dones_b == n; c++) begin
                    sb.OUTREADY = 1'($urandom_range(0, 1));
                    tick();
                end
                sb.OUTREADY = 1'b1;
                check("b_rand_dones", dones_b - n, 1);
            end
            if (d == 0) begin
                check("b_done_cycle", done_cyc_b - s, 20);
                check("b_first_latency", lat_b - s, 3);
            end
            check("b_fin_rdaddr", rdaddr_b, 0);
            check("b_beats", beats_b - b0, 5);
            tick();
            check("b_busy_after", busy_b, 0);
            check("b_queue_empty", exp_b.size(), 0);
        end
        check("b_max_addr", max_b, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test by %0t want finish", $time);
        $fatal(1);
    end

endmodule
